clock_tick_ctrl: RTL

Sequencer that owns the `ena` input of `clock_counter`. In normal running it emits one single-cycle `ena` pulse per second from a clock-divider prescaler. On a time-set button press it issues a back-to-back burst of `ena` pulses: 60 pulses to advance one minute, 3600 to advance one hour. Seconds ticks that fall inside a burst are folded into the burst, so no time is lost. It sits between the board buttons and `clock_counter`; its `ena` output connects directly to `clock_counter.ena`.

---
 rtl/clock_tick_ctrl_if.sv | 27 ++
 rtl/clock_tick_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clock_tick_ctrl_if.sv
// Board-side signal bundle for clock_tick_ctrl: run control and time-set
// buttons in, advance pulse and burst status out.
interface clock_tick_ctrl_if;
  logic run_en;
  logic btn_min;
  logic btn_hour;
  logic ena;
  logic busy;

  // Board / stimulus side.
  modport master (
    output run_en,
    output btn_min,
    output btn_hour,
    input  ena,
    input  busy
  );

  // Sequencer side.
  modport slave (
    input  run_en,
    input  btn_min,
    input  btn_hour,
    output ena,
    output busy
  );
endinterface

// File: rtl/clock_tick_ctrl.sv
// Sequencer that owns clock_counter's advance enable. In normal running it
// emits one single-cycle pulse per second from a prescaler. A minute or hour
// button edge turns into a back-to-back burst of pulses. Seconds ticks that
// land inside a burst are folded into the burst so no time is lost.
module clock_tick_ctrl #(
  parameter int unsigned SEC_DIV     = 100000000,
  parameter int unsigned MIN_PULSES  = 60,
  parameter int unsigned HOUR_PULSES = 3600
) (
  input logic              clk,
  input logic              reset,
  clock_tick_ctrl_if.slave bus
);

  localparam int unsigned PcntW  = $clog2(SEC_DIV);
  localparam int unsigned RemW   = 13;
  localparam int unsigned RemMax = (1 << RemW) - 1;

  localparam logic [PcntW-1:0] PcntMax = PcntW'(SEC_DIV - 1);

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } state_e;

  // Button synchronisers: bit 0 and bit 1 form the 2-flop synchroniser,
  // bit 2 holds the previous synchronised value for edge detection.
  logic [2:0] min_sync_q;
  logic [2:0] hour_sync_q;
  logic       rise_min;
  logic       rise_hour;

  logic [PcntW-1:0] pcnt_q;
  logic             sec_tick;

  state_e          state_q;
  logic [RemW-1:0] rem_q;
  logic            ena_q;
  logic            busy_q;

  logic [31:0]     load_sum;
  logic [RemW-1:0] load_rem;
  logic [RemW-1:0] rem_dec;
  logic            burst_last;
  logic            load_req;

  // Shift asynchronous button levels into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_sync_q  <= 3'b000;
      hour_sync_q <= 3'b000;
    end else begin
      min_sync_q  <= {min_sync_q[1:0], bus.btn_min};
      hour_sync_q <= {hour_sync_q[1:0], bus.btn_hour};
    end
  end

  assign rise_min  = min_sync_q[1] & ~min_sync_q[2];
  assign rise_hour = hour_sync_q[1] & ~hour_sync_q[2];

  // Seconds prescaler; keeps its phase through bursts and holds while stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (bus.run_en) begin
      if (pcnt_q == PcntMax) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + PcntW'(1);
      end
    end
  end

  assign sec_tick = (pcnt_q == PcntMax) & bus.run_en;

  // Burst length on a request: requested pulses plus any tick in this cycle,
  // saturated to the width of the remaining counter.
  always_comb begin
    load_sum = {31'd0, sec_tick};
    if (rise_min) begin
      load_sum = load_sum + MIN_PULSES;
    end
    if (rise_hour) begin
      load_sum = load_sum + HOUR_PULSES;
    end
    if (load_sum > RemMax) begin
      load_rem = RemW'(RemMax);
    end else begin
      load_rem = load_sum[RemW-1:0];
    end
  end

  // A zero-length request (only possible with zero pulse parameters) is ignored.
  assign load_req = (rise_min | rise_hour) & (load_rem != '0);

  // During a burst a coincident tick replaces the pulse being consumed, so the
  // count only drops on tick-free cycles and cannot overflow.
  assign rem_dec    = sec_tick ? rem_q : (rem_q - RemW'(1));
  assign burst_last = (rem_q <= RemW'(1)) & ~sec_tick;

  // Sequencer FSM with registered ena/busy. busy is set on the load cycle and
  // stays set through the cycle that carries the final pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_req) begin
            // The tick of this cycle, if any, is carried inside rem.
            state_q <= StBurst;
            rem_q   <= load_rem;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ena_q  <= sec_tick;
            busy_q <= 1'b0;
          end
        end
        StBurst: begin
          // Button edges seen here are deliberately dropped.
          ena_q  <= 1'b1;
          busy_q <= 1'b1;
          if (burst_last) begin
            state_q <= StIdle;
            rem_q   <= '0;
          end else begin
            rem_q <= rem_dec;
          end
        end
        default: begin
          state_q <= StIdle;
          rem_q   <= '0;
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ena  = ena_q;
  assign bus.busy = busy_q;

endmodule
